note_box_drawer: RTL and testbench

- Pixel-generation datapath directly downstream of the game control FSM.
- Consumes the FSM strobes loadDefault/writeDefault (background clear) and loadStartAddress/startingAddressLoaded (note box draw), plus the box index.
- Emits one pixel per cycle (x, y, colour, plot) to the 240x180 VGA adapter, and returns shapeDone to the FSM when a box is finished.

---
 rtl/video_pkg.sv | 42 ++++
 rtl/raster_counter.sv | 51 +++++
 rtl/note_box_drawer.sv | 210 +++++++++++++++++++++
 tb/tb_note_box_drawer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants and types for the note-box pixel datapath: screen
// geometry of the 240x180 VGA adapter, colour codes, box indexing and the
// box-draw state encoding.
package video_pkg;

    // Screen geometry
    localparam int unsigned GRID_W      = 240;
    localparam int unsigned GRID_H      = 180;
    localparam int unsigned GRID_PIXELS = GRID_W * GRID_H;   // 43200

    // Coordinate and colour widths
    localparam int unsigned COORD_W  = 8;
    localparam int unsigned COLOUR_W = 3;

    // Colour codes
    localparam logic [COLOUR_W-1:0] COL_BG    = 3'b000;
    localparam logic [COLOUR_W-1:0] COL_NOTE  = 3'b010;
    localparam logic [COLOUR_W-1:0] COL_EMPTY = 3'b111;

    // Box indexing: 4 lanes x 3 rows of boxes, addressed by a 4-bit index
    localparam int unsigned BOX_IDX_W = 4;
    localparam int unsigned NUM_SLOTS = 1 << BOX_IDX_W;      // 16 encodable indices
    localparam int unsigned NUM_BOXES = 12;                  // indices 0..11 are real boxes
    localparam int unsigned NUM_LANES = 4;

    // Box-draw sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } draw_state_t;

    // Origin of a lane/row along one axis; wraps in 8-bit screen coordinates
    function automatic logic [COORD_W-1:0] axis_origin(
        input int unsigned base,
        input int unsigned pitch,
        input int unsigned idx
    );
        return COORD_W'(base + pitch * idx);
    endfunction

endpackage : video_pkg

// File: rtl/raster_counter.sv
// Full-screen raster position for the background clear. Walks x fastest,
// then y, and parks on the last pixel with end_o set so that surplus
// advance requests are harmless.
module raster_counter
    import video_pkg::*;
#(
    parameter int unsigned X_LAST = GRID_W - 1,
    parameter int unsigned Y_LAST = GRID_H - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               adv_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               end_o
);

    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic               end_q;

    // Raster position: clear has priority, advance stops once the end flag is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            end_q <= 1'b0;
        end else if (clr_i) begin
            x_q   <= '0;
            y_q   <= '0;
            end_q <= 1'b0;
        end else if (adv_i && !end_q) begin
            if (x_q == COORD_W'(X_LAST)) begin
                if (y_q == COORD_W'(Y_LAST)) begin
                    end_q <= 1'b1;
                end else begin
                    x_q <= '0;
                    y_q <= y_q + 1'b1;
                end
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign end_o = end_q;

endmodule : raster_counter

// File: rtl/note_box_drawer.sv
// Pixel generator behind the game control FSM. Emits one registered pixel
// per cycle: either a background-clear pixel from the full-screen raster, or
// a pixel of a 16x16 note box whose origin and colour were latched from the
// box index. Signals shapeDone for one cycle when a box has been drawn.
module note_box_drawer
    import video_pkg::*;
#(
    parameter int unsigned          BOX_W        = 16,
    parameter int unsigned          BOX_H        = 16,
    parameter int unsigned          X_BASE       = 24,
    parameter int unsigned          LANE_PITCH   = 56,
    parameter int unsigned          Y_BASE       = 20,
    parameter int unsigned          ROW_PITCH    = 56,
    parameter logic [COLOUR_W-1:0]  BG_COLOUR    = COL_BG,
    parameter logic [COLOUR_W-1:0]  NOTE_COLOUR  = COL_NOTE,
    parameter logic [COLOUR_W-1:0]  EMPTY_COLOUR = COL_EMPTY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  loadDefault,
    input  logic                  writeDefault,
    input  logic                  loadStartAddress,
    input  logic                  startingAddressLoaded,
    input  logic [BOX_IDX_W-1:0]  boxCounter,
    input  logic [NUM_BOXES-1:0]  noteMap,
    output logic [COORD_W-1:0]    x,
    output logic [COORD_W-1:0]    y,
    output logic [COLOUR_W-1:0]   colour,
    output logic                  plot,
    output logic                  shapeDone
);

    localparam int unsigned BX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int unsigned BY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [BX_W-1:0] BX_LAST = BX_W'(BOX_W - 1);
    localparam logic [BY_W-1:0] BY_LAST = BY_W'(BOX_H - 1);

    // loadDefault carries no work here: the background pixel is produced on writeDefault
    logic unused_load_default;
    assign unused_load_default = loadDefault;

    // ------------------------------------------------------------------
    // Box geometry lookup: one entry per encodable index
    // ------------------------------------------------------------------
    logic [COORD_W-1:0]  org_x_tab [NUM_SLOTS];
    logic [COORD_W-1:0]  org_y_tab [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_tab;
    logic [NUM_SLOTS-1:0] note_ext;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_box_geom
        // lane = index[1:0], row = index[3:2]
        assign org_x_tab[gi] = axis_origin(X_BASE, LANE_PITCH, gi % NUM_LANES);
        assign org_y_tab[gi] = axis_origin(Y_BASE, ROW_PITCH,  gi / NUM_LANES);
        assign valid_tab[gi] = (gi < NUM_BOXES);
    end

    // Indices beyond the real boxes read as inactive notes
    assign note_ext = {{(NUM_SLOTS - NUM_BOXES){1'b0}}, noteMap};

    // ------------------------------------------------------------------
    // Latched box description
    // ------------------------------------------------------------------
    logic [COORD_W-1:0]  org_x_q;
    logic [COORD_W-1:0]  org_y_q;
    logic [COLOUR_W-1:0] box_colour_q;
    logic                box_valid_q;

    // ------------------------------------------------------------------
    // Sequencer and output registers
    // ------------------------------------------------------------------
    draw_state_t         state_q,   state_d;
    logic [BX_W-1:0]     bx_q,      bx_d;
    logic [BY_W-1:0]     by_q,      by_d;
    logic [COORD_W-1:0]  x_q,       x_d;
    logic [COORD_W-1:0]  y_q,       y_d;
    logic [COLOUR_W-1:0] colour_q,  colour_d;
    logic                plot_q,    plot_d;
    logic                done_q,    done_d;

    // Background raster interface
    logic                raster_clr;
    logic                raster_adv;
    logic [COORD_W-1:0]  raster_x;
    logic [COORD_W-1:0]  raster_y;
    logic                raster_end;

    raster_counter #(
        .X_LAST (GRID_W - 1),
        .Y_LAST (GRID_H - 1)
    ) u_raster (
        .clk   (clock),
        .rst   (reset),
        .clr_i (raster_clr),
        .adv_i (raster_adv),
        .x_o   (raster_x),
        .y_o   (raster_y),
        .end_o (raster_end)
    );

    // Capture origin, colour and validity of the requested box; frozen while drawing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            org_x_q      <= '0;
            org_y_q      <= '0;
            box_colour_q <= '0;
            box_valid_q  <= 1'b0;
        end else if (loadStartAddress && (state_q != ST_DRAW)) begin
            org_x_q      <= org_x_tab[boxCounter];
            org_y_q      <= org_y_tab[boxCounter];
            box_colour_q <= note_ext[boxCounter] ? NOTE_COLOUR : EMPTY_COLOUR;
            box_valid_q  <= valid_tab[boxCounter];
        end
    end

    // Next-state and next-pixel decode; plot and shapeDone default low every cycle
    always_comb begin
        state_d    = state_q;
        bx_d       = bx_q;
        by_d       = by_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        done_d     = 1'b0;
        raster_clr = 1'b0;
        raster_adv = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (startingAddressLoaded) begin
                    // A box draw also rewinds the background raster
                    state_d    = ST_DRAW;
                    bx_d       = '0;
                    by_d       = '0;
                    raster_clr = 1'b1;
                end else if (writeDefault && !raster_end) begin
                    x_d        = raster_x;
                    y_d        = raster_y;
                    colour_d   = BG_COLOUR;
                    plot_d     = 1'b1;
                    raster_adv = 1'b1;
                end
            end

            ST_DRAW: begin
                // Coordinates are emitted even for an invalid box; plot gates them off
                x_d      = org_x_q + COORD_W'(bx_q);
                y_d      = org_y_q + COORD_W'(by_q);
                colour_d = box_colour_q;
                plot_d   = box_valid_q;
                if (bx_q == BX_LAST) begin
                    bx_d = '0;
                    if (by_q == BY_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        by_d = by_q + 1'b1;
                    end
                end else begin
                    bx_d = bx_q + 1'b1;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and box-local pixel counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bx_q    <= '0;
            by_q    <= '0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
        end
    end

    // Registered pixel outputs towards the VGA adapter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign shapeDone = done_q;

endmodule : note_box_drawer

// File: tb/tb_note_box_drawer.sv
// Directed bench for note_box_drawer: background clear over the whole screen,
// valid/empty/invalid box draws, mid-draw disturbances and mid-draw reset.
module tb_note_box_drawer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        loadDefault = 1'b0;
    logic        writeDefault = 1'b0;
    logic        loadStartAddress = 1'b0;
    logic        startingAddressLoaded = 1'b0;
    logic [3:0]  boxCounter = 4'd0;
    logic [11:0] noteMap = 12'd0;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        shapeDone;

    int vectors = 0;
    int miscompares = 0;

    note_box_drawer dut (
        .clock                 (clock),
        .reset                 (reset),
        .loadDefault           (loadDefault),
        .writeDefault          (writeDefault),
        .loadStartAddress      (loadStartAddress),
        .startingAddressLoaded (startingAddressLoaded),
        .boxCounter            (boxCounter),
        .noteMap               (noteMap),
        .x                     (x),
        .y                     (y),
        .colour                (colour),
        .plot                  (plot),
        .shapeDone             (shapeDone)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #2;
        vectors++;
        if (x !== 8'd0 || y !== 8'd0 || colour !== 3'd0 || plot !== 1'b0 || shapeDone !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got x=%0d y=%0d col=%b plot=%b done=%b expected all zero",
                     x, y, colour, plot, shapeDone);
        end
        step();
        step();
        reset = 1'b0;
        $display("reset: outputs checked");
    endtask

    // 43200 raster pixels then one suppressed terminal write
    task automatic test_background();
        logic [7:0] ex, ey;
        int bad = 0;
        writeDefault = 1'b1;
        for (int i = 0; i < 43200; i++) begin
            step();
            ex = 8'(i % 240);
            ey = 8'(i / 240);
            vectors++;
            if (plot !== 1'b1 || x !== ex || y !== ey || colour !== 3'b000 || shapeDone !== 1'b0) begin
                miscompares++;
                bad++;
                if (bad < 20)
                    $display("FAIL bg_pixel i=%0d got x=%0d y=%0d plot=%b col=%b expected x=%0d y=%0d plot=1 col=000",
                             i, x, y, plot, colour, ex, ey);
            end
        end
        step();
        writeDefault = 1'b0;
        vectors++;
        if (plot !== 1'b0) begin
            miscompares++;
            $display("FAIL bg_extra_write got plot=%b expected 0", plot);
        end
        $display("background: 43200 pixels + terminal write checked, %0d bad", bad);
    endtask

    // Load a box, start it and check every pixel plus the shapeDone pulse.
    // inject_at >= 0 pulses writeDefault/startingAddressLoaded/loadStartAddress mid-draw.
    task automatic test_box(input string name, input logic [3:0] idx, input logic [11:0] map,
                            input logic [7:0] x0, input logic [7:0] y0, input logic [2:0] col,
                            input logic vis, input int inject_at);
        logic [7:0] ex, ey;
        int bad = 0;
        boxCounter = idx;
        noteMap = map;
        loadStartAddress = 1'b1;
        step();
        loadStartAddress = 1'b0;
        startingAddressLoaded = 1'b1;
        step();
        startingAddressLoaded = 1'b0;
        vectors++;
        if (plot !== 1'b0 || shapeDone !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_start got plot=%b done=%b expected 0 0", name, plot, shapeDone);
        end
        for (int p = 0; p < 256; p++) begin
            step();
            writeDefault = 1'b0;
            startingAddressLoaded = 1'b0;
            loadStartAddress = 1'b0;
            boxCounter = idx;
            ex = x0 + 8'(p % 16);
            ey = y0 + 8'(p / 16);
            vectors++;
            if (vis) begin
                if (plot !== 1'b1 || x !== ex || y !== ey || colour !== col || shapeDone !== 1'b0) begin
                    miscompares++;
                    bad++;
                    if (bad < 20)
                        $display("FAIL %s_pixel p=%0d got x=%0d y=%0d col=%b plot=%b done=%b expected x=%0d y=%0d col=%b plot=1 done=0",
                                 name, p, x, y, colour, plot, shapeDone, ex, ey, col);
                end
            end else if (plot !== 1'b0 || shapeDone !== 1'b0) begin
                miscompares++;
                bad++;
                if (bad < 20)
                    $display("FAIL %s_hidden p=%0d got plot=%b done=%b expected 0 0", name, p, plot, shapeDone);
            end
            if (p == inject_at) begin
                writeDefault = 1'b1;
                startingAddressLoaded = 1'b1;
                loadStartAddress = 1'b1;
                boxCounter = 4'd0;
            end
        end
        step();
        vectors++;
        if (shapeDone !== 1'b1 || plot !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done got done=%b plot=%b expected done=1 plot=0", name, shapeDone, plot);
        end
        step();
        vectors++;
        if (shapeDone !== 1'b0 || plot !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_after got done=%b plot=%b expected 0 0", name, shapeDone, plot);
        end
        $display("box %s: idx=%0d origin=(%0d,%0d) 256 cycles checked, %0d bad", name, idx, x0, y0, bad);
    endtask

    // A box draw rewinds the raster, so background writes resume at (0,0)
    task automatic test_raster_restart();
        writeDefault = 1'b1;
        step();
        vectors++;
        if (plot !== 1'b1 || x !== 8'd0 || y !== 8'd0 || colour !== 3'b000) begin
            miscompares++;
            $display("FAIL raster_restart0 got x=%0d y=%0d plot=%b col=%b expected x=0 y=0 plot=1 col=000",
                     x, y, plot, colour);
        end
        step();
        writeDefault = 1'b0;
        vectors++;
        if (plot !== 1'b1 || x !== 8'd1 || y !== 8'd0) begin
            miscompares++;
            $display("FAIL raster_restart1 got x=%0d y=%0d plot=%b expected x=1 y=0 plot=1", x, y, plot);
        end
        step();
        vectors++;
        if (plot !== 1'b0) begin
            miscompares++;
            $display("FAIL raster_idle got plot=%b expected 0", plot);
        end
        $display("raster restart: (0,0),(1,0) then idle checked");
    endtask

    // Reset asserted after pixel 100: plot drops at once and no shapeDone follows
    task automatic test_reset_mid_draw();
        int bad = 0;
        boxCounter = 4'd11;
        noteMap = 12'h800;
        loadStartAddress = 1'b1;
        step();
        loadStartAddress = 1'b0;
        startingAddressLoaded = 1'b1;
        step();
        startingAddressLoaded = 1'b0;
        for (int p = 0; p <= 100; p++) step();
        vectors++;
        if (plot !== 1'b1 || x !== 8'd196 || y !== 8'd138) begin
            miscompares++;
            $display("FAIL pre_reset_pixel got x=%0d y=%0d plot=%b expected x=196 y=138 plot=1", x, y, plot);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (plot !== 1'b0 || shapeDone !== 1'b0 || x !== 8'd0 || y !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset got x=%0d y=%0d plot=%b done=%b expected 0 0 0 0", x, y, plot, shapeDone);
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (plot !== 1'b0 || shapeDone !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL post_reset_quiet got %0d active cycles expected 0", bad);
        end
        $display("reset mid-draw: drop and 300 quiet cycles checked");
    endtask

    initial begin
        test_reset();
        test_background();
        test_box("box5_note", 4'd5, 12'h020, 8'd80, 8'd76, 3'b010, 1'b1, -1);
        test_raster_restart();
        test_box("box11_empty", 4'd11, 12'h000, 8'd192, 8'd132, 3'b111, 1'b1, -1);
        test_box("box12_invalid", 4'd12, 12'hFFF, 8'd0, 8'd0, 3'b111, 1'b0, -1);
        test_box("box5_disturbed", 4'd5, 12'h020, 8'd80, 8'd76, 3'b010, 1'b1, 50);
        test_reset_mid_draw();
        test_box("box5_fresh", 4'd5, 12'h020, 8'd80, 8'd76, 3'b010, 1'b1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_note_box_drawer
